// File: rtl/sdr_init_monitor_pkg.sv
// Shared types for the SDRAM init monitor: pad-bus command codes, init FSM
// states and the error cause codes reported on err_code.
package sdr_init_pkg;

   typedef enum logic [2:0] {NOP, PRE, AREF, LMR, ACT, RD, WR, BST} sdr_cmd_e;

   typedef enum logic [2:0] {S_IDLE, S_NOP, S_AREF, S_LMR, S_DONE, S_ERR} init_state_e;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_EARLY   = 3'd1;
   localparam logic [2:0] ERR_TIMEOUT = 3'd2;
   localparam logic [2:0] ERR_ILLEGAL = 3'd3;
   localparam logic [2:0] ERR_PRE_A10 = 3'd4;
   localparam logic [2:0] ERR_TIMING  = 3'd5;
   localparam logic [2:0] ERR_ACCESS  = 3'd6;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sdr_init_monitor_cmd_decode.sv
// sdr_cmd_decode: combinational decode of the SDRAM control pins into a
// command code. A deselected device (cs_n high) always reads as NOP.
module sdr_cmd_decode
   import sdr_init_pkg::*;
(
   input  logic       cs_n_i,
   input  logic       ras_n_i,
   input  logic       cas_n_i,
   input  logic       we_n_i,
   output logic [2:0] cmd_o
);

   always_comb begin
      cmd_o = NOP;
      if (!cs_n_i) begin
         case ({ras_n_i, cas_n_i, we_n_i})
            3'b111:  cmd_o = NOP;
            3'b010:  cmd_o = PRE;
            3'b001:  cmd_o = AREF;
            3'b000:  cmd_o = LMR;
            3'b011:  cmd_o = ACT;
            3'b101:  cmd_o = RD;
            3'b100:  cmd_o = WR;
            default: cmd_o = BST;
         endcase
      end
   end

endmodule

// File: rtl/sdr_init_monitor.sv
// sdr_init_monitor: checks the SDRAM power-up sequence (NOP window, PRECHARGE-ALL,
// AUTO-REFRESHes, LOAD MODE). Define SDR_INIT_TIMING_CHECK_EN to add tRP/tRFC spacing checks.
module sdr_init_monitor
   import sdr_init_pkg::*;
#(
   parameter int SDR_AW       = 13,
   parameter int SDR_BW       = 2,
   parameter int INIT_NOP_CYC = 600,
   parameter int NUM_AREF     = 2,
   parameter int MAX_GAP      = 100,
   parameter int TRP_CYC      = 3,
   parameter int TRFC_CYC     = 7
) (
   input  logic                     sdram_clk,
   input  logic                     sdram_reset,
   input  logic                     sdr_cs_n,
   input  logic                     sdr_ras_n,
   input  logic                     sdr_cas_n,
   input  logic                     sdr_we_n,
   input  logic [SDR_AW-1:0]        sdr_addr,
   input  logic [SDR_BW-1:0]        sdr_ba,
   output logic                     init_done,
   output logic                     init_err,
   output logic [2:0]               err_code,
   output logic [3:0]               aref_cnt,
   output logic [SDR_AW+SDR_BW-1:0] mode_reg,
   output logic [2:0]               dbg_state
);

   // TRP_CYC is folded in so the shared counter width also holds the tRP load value.
   localparam int CW = $clog2(max_of(max_of(INIT_NOP_CYC, MAX_GAP),
                                     max_of(TRFC_CYC, TRP_CYC)) + 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] NOP_LIM  = CW'(INIT_NOP_CYC);
   localparam logic [CW-1:0] GAP_LIM  = CW'(MAX_GAP);
   localparam logic [3:0]    AREF_TGT = 4'(NUM_AREF);

   init_state_e                state_q, state_d;
   logic [CW-1:0]              cnt_q, cnt_d, cnt_inc;
   logic [3:0]                 aref_q, aref_d, aref_inc;
   logic [2:0]                 code_q, code_d;
   logic [SDR_AW+SDR_BW-1:0]   mode_q, mode_d;
   logic [2:0]                 cmd_raw;
   sdr_cmd_e                   cmd;
   logic                       timing_viol;

   sdr_cmd_decode u_decode (
      .cs_n_i  (sdr_cs_n),
      .ras_n_i (sdr_ras_n),
      .cas_n_i (sdr_cas_n),
      .we_n_i  (sdr_we_n),
      .cmd_o   (cmd_raw)
   );

   assign cmd      = sdr_cmd_e'(cmd_raw);
   assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
   assign aref_inc = (aref_q == 4'hF) ? aref_q : aref_q + 4'd1;

`ifdef SDR_INIT_TIMING_CHECK_EN
   localparam logic [CW-1:0] TRP_LD  = CW'((TRP_CYC  > 0) ? TRP_CYC  - 1 : 0);
   localparam logic [CW-1:0] TRFC_LD = CW'((TRFC_CYC > 0) ? TRFC_CYC - 1 : 0);

   logic [CW-1:0] sp_q, sp_d;

   // Loads on the command itself, so the next command is legal once it has drained to 0.
   always_comb begin
      sp_d = (sp_q != '0) ? sp_q - 1'b1 : '0;
      if (state_q == S_NOP && state_d == S_AREF) begin
         sp_d = TRP_LD;
      end else if (cmd == AREF && (state_q == S_AREF || state_q == S_LMR)
                   && state_d != S_ERR) begin
         sp_d = TRFC_LD;
      end
   end

   always_ff @(posedge sdram_clk or posedge sdram_reset) begin
      if (sdram_reset) sp_q <= '0;
      else             sp_q <= sp_d;
   end

   assign timing_viol = (sp_q != '0) && (cmd != NOP);
`else
   assign timing_viol = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      aref_d  = aref_q;
      code_d  = code_q;
      mode_d  = mode_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_NOP;
            cnt_d   = '0;
         end
         S_NOP: begin
            if (cmd == NOP) begin
               cnt_d = cnt_inc;
            end else if (cnt_q < NOP_LIM) begin
               state_d = S_ERR;
               code_d  = ERR_EARLY;
            end else if (cmd == PRE && sdr_addr[10]) begin
               state_d = S_AREF;
               cnt_d   = '0;
            end else begin
               state_d = S_ERR;
               code_d  = (cmd == PRE) ? ERR_PRE_A10 : ERR_ILLEGAL;
            end
         end
         S_AREF, S_LMR: begin
            // cnt_q now counts idle cycles since the last sequence command.
            if (cmd == NOP) begin
               if (cnt_q >= GAP_LIM) begin
                  state_d = S_ERR;
                  code_d  = ERR_TIMEOUT;
               end else begin
                  cnt_d = cnt_inc;
               end
            end else if (timing_viol) begin
               state_d = S_ERR;
               code_d  = ERR_TIMING;
            end else if (cmd == AREF) begin
               cnt_d  = '0;
               aref_d = aref_inc;
               if (state_q == S_AREF && aref_inc == AREF_TGT) state_d = S_LMR;
            end else if (cmd == LMR && state_q == S_LMR) begin
               mode_d  = {sdr_ba, sdr_addr};
               state_d = S_DONE;
            end else begin
               state_d = S_ERR;
               code_d  = (cmd == ACT || cmd == RD || cmd == WR) ? ERR_ACCESS : ERR_ILLEGAL;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge sdram_clk or posedge sdram_reset) begin
      if (sdram_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         aref_q  <= '0;
         code_q  <= ERR_NONE;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         aref_q  <= aref_d;
         code_q  <= code_d;
         mode_q  <= mode_d;
      end
   end

   assign init_done = (state_q == S_DONE);
   assign init_err  = (state_q == S_ERR);
   assign err_code  = code_q;
   assign aref_cnt  = aref_q;
   assign mode_reg  = mode_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sdr_init_monitor.sv
// Directed bench for sdr_init_monitor: a table of {NOP run, command, expected outputs}
// rows plus hand-written sequences for timeout, async reset, saturation and spacing.
module tb_sdr_init_monitor;

   localparam logic [3:0] P_NOP   = 4'b0111;
   localparam logic [3:0] P_PRE   = 4'b0010;
   localparam logic [3:0] P_AREF  = 4'b0001;
   localparam logic [3:0] P_LMR   = 4'b0000;
   localparam logic [3:0] P_ACT   = 4'b0011;
   localparam logic [3:0] P_RD    = 4'b0101;
   localparam logic [3:0] P_WR    = 4'b0100;
   localparam logic [3:0] P_BST   = 4'b0110;
   localparam logic [3:0] P_DESEL = 4'b1000;
   localparam logic [12:0] A10    = 13'h0400;

   logic        clk = 1'b0;
   logic        sdram_reset = 1'b1;
   logic        cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
   logic [12:0] addr = '0;
   logic [1:0]  ba = '0;
   logic        init_done, init_err;
   logic [2:0]  err_code;
   logic [3:0]  aref_cnt;
   logic [14:0] mode_reg;
   logic [2:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sdr_init_monitor dut (
      .sdram_clk   (clk),
      .sdram_reset (sdram_reset),
      .sdr_cs_n    (cs_n),
      .sdr_ras_n   (ras_n),
      .sdr_cas_n   (cas_n),
      .sdr_we_n    (we_n),
      .sdr_addr    (addr),
      .sdr_ba      (ba),
      .init_done   (init_done),
      .init_err    (init_err),
      .err_code    (err_code),
      .aref_cnt    (aref_cnt),
      .mode_reg    (mode_reg),
      .dbg_state   (dbg_state)
   );

   typedef struct {
      logic        rst;
      int          nops;
      logic [3:0]  pins;
      logic [12:0] addr;
      logic [1:0]  ba;
      logic        done;
      logic        err;
      logic [2:0]  code;
      logic [3:0]  aref;
      logic [14:0] mode;
   } vec_t;

   vec_t vecs[35];

   function automatic vec_t mk(input logic r, input int n, input logic [3:0] p,
                               input logic [12:0] a, input logic d, input logic e,
                               input logic [2:0] c, input logic [3:0] ar,
                               input logic [14:0] m);
      vec_t v;
      v.rst = r; v.nops = n; v.pins = p; v.addr = a; v.ba = 2'd0;
      v.done = d; v.err = e; v.code = c; v.aref = ar; v.mode = m;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_outs(input string nm, input logic d, input logic e,
                           input logic [2:0] c, input logic [3:0] ar, input logic [14:0] m);
      chk({nm, "_done"}, 32'(init_done), 32'(d));
      chk({nm, "_err"},  32'(init_err),  32'(e));
      chk({nm, "_code"}, 32'(err_code),  32'(c));
      chk({nm, "_aref"}, 32'(aref_cnt),  32'(ar));
      chk({nm, "_mode"}, 32'(mode_reg),  32'(m));
   endtask

   task automatic cyc(input logic [3:0] p, input logic [12:0] a, input logic [1:0] b);
      {cs_n, ras_n, cas_n, we_n} = p;
      addr = a;
      ba   = b;
      @(posedge clk);
      #1;
   endtask

   task automatic nops(input int n);
      for (int k = 0; k < n; k++) cyc(P_NOP, 13'h0, 2'd0);
   endtask

   // Reset, release away from the edge, then consume the idle cycle after release.
   task automatic do_reset();
      {cs_n, ras_n, cas_n, we_n} = P_NOP;
      sdram_reset = 1'b1;
      @(posedge clk);
      #1;
      sdram_reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic legal_to_pre();
      do_reset();
      nops(600);
      cyc(P_PRE, A10, 2'd0);
   endtask

   initial begin
      vecs[0]  = mk(1'b1, 600, P_PRE,   A10,      1'b0, 1'b0, 3'd0, 4'd0, 15'h0);
      vecs[1]  = mk(1'b0, 5,   P_AREF,  13'h0,    1'b0, 1'b0, 3'd0, 4'd1, 15'h0);
      vecs[2]  = mk(1'b0, 10,  P_AREF,  13'h0,    1'b0, 1'b0, 3'd0, 4'd2, 15'h0);
      vecs[3]  = mk(1'b0, 10,  P_LMR,   13'h033,  1'b1, 1'b0, 3'd0, 4'd2, 15'h0033);
      vecs[4]  = mk(1'b0, 3,   P_ACT,   13'h0,    1'b1, 1'b0, 3'd0, 4'd2, 15'h0033);
      vecs[5]  = mk(1'b1, 599, P_PRE,   A10,      1'b0, 1'b1, 3'd1, 4'd0, 15'h0);
      vecs[6]  = mk(1'b0, 0,   P_PRE,   A10,      1'b0, 1'b1, 3'd1, 4'd0, 15'h0);
      vecs[7]  = mk(1'b1, 600, P_PRE,   A10,      1'b0, 1'b0, 3'd0, 4'd0, 15'h0);
      vecs[8]  = mk(1'b0, 100, P_AREF,  13'h0,    1'b0, 1'b0, 3'd0, 4'd1, 15'h0);
      vecs[9]  = mk(1'b0, 8,   P_AREF,  13'h0,    1'b0, 1'b0, 3'd0, 4'd2, 15'h0);
      vecs[10] = mk(1'b0, 100, P_LMR,   13'h0,    1'b1, 1'b0, 3'd0, 4'd2, 15'h0);
      vecs[11] = mk(1'b1, 600, P_PRE,   13'h0,    1'b0, 1'b1, 3'd4, 4'd0, 15'h0);
      vecs[12] = mk(1'b1, 600, P_PRE,   A10,      1'b0, 1'b0, 3'd0, 4'd0, 15'h0);
      vecs[13] = mk(1'b0, 5,   P_AREF,  13'h0,    1'b0, 1'b0, 3'd0, 4'd1, 15'h0);
      vecs[14] = mk(1'b0, 8,   P_ACT,   13'h0,    1'b0, 1'b1, 3'd6, 4'd1, 15'h0);
      vecs[15] = mk(1'b1, 600, P_BST,   13'h0,    1'b0, 1'b1, 3'd3, 4'd0, 15'h0);
      vecs[16] = mk(1'b1, 600, P_PRE,   A10,      1'b0, 1'b0, 3'd0, 4'd0, 15'h0);
      vecs[17] = mk(1'b0, 8,   P_AREF,  13'h0,    1'b0, 1'b0, 3'd0, 4'd1, 15'h0);
      vecs[18] = mk(1'b0, 8,   P_AREF,  13'h0,    1'b0, 1'b0, 3'd0, 4'd2, 15'h0);
      vecs[19] = mk(1'b0, 8,   P_AREF,  13'h0,    1'b0, 1'b0, 3'd0, 4'd3, 15'h0);
      vecs[20] = mk(1'b0, 8,   P_RD,    13'h0,    1'b0, 1'b1, 3'd6, 4'd3, 15'h0);
      vecs[21] = mk(1'b1, 600, P_PRE,   A10,      1'b0, 1'b0, 3'd0, 4'd0, 15'h0);
      vecs[22] = mk(1'b0, 8,   P_LMR,   13'h0,    1'b0, 1'b1, 3'd3, 4'd0, 15'h0);
      vecs[23] = mk(1'b1, 600, P_DESEL, 13'h0,    1'b0, 1'b0, 3'd0, 4'd0, 15'h0);
      vecs[24] = mk(1'b0, 0,   P_PRE,   A10,      1'b0, 1'b0, 3'd0, 4'd0, 15'h0);
      vecs[25] = mk(1'b0, 8,   P_AREF,  13'h0,    1'b0, 1'b0, 3'd0, 4'd1, 15'h0);
      vecs[26] = mk(1'b0, 8,   P_WR,    13'h0,    1'b0, 1'b1, 3'd6, 4'd1, 15'h0);
      vecs[27] = mk(1'b1, 0,   P_ACT,   13'h0,    1'b0, 1'b1, 3'd1, 4'd0, 15'h0);
      vecs[28] = mk(1'b1, 600, P_PRE,   A10,      1'b0, 1'b0, 3'd0, 4'd0, 15'h0);
      vecs[29] = mk(1'b0, 8,   P_AREF,  13'h0,    1'b0, 1'b0, 3'd0, 4'd1, 15'h0);
      vecs[30] = mk(1'b0, 8,   P_PRE,   A10,      1'b0, 1'b1, 3'd3, 4'd1, 15'h0);
      vecs[31] = mk(1'b1, 600, P_PRE,   A10,      1'b0, 1'b0, 3'd0, 4'd0, 15'h0);
      vecs[32] = mk(1'b0, 8,   P_AREF,  13'h0,    1'b0, 1'b0, 3'd0, 4'd1, 15'h0);
      vecs[33] = mk(1'b0, 8,   P_AREF,  13'h0,    1'b0, 1'b0, 3'd0, 4'd2, 15'h0);
      vecs[34] = mk(1'b0, 8,   P_BST,   13'h0,    1'b0, 1'b1, 3'd3, 4'd2, 15'h0);

      // Reset state, observed while reset is held.
      @(posedge clk);
      #1;
      chk_outs("reset", 1'b0, 1'b0, 3'd0, 4'd0, 15'h0);

      for (int i = 0; i < 35; i++) begin
         if (vecs[i].rst) do_reset();
         nops(vecs[i].nops);
         if (i == 3) chk("row3_done_before_lmr", 32'(init_done), 32'd0);
         cyc(vecs[i].pins, vecs[i].addr, vecs[i].ba);
         chk_outs($sformatf("row%0d", i), vecs[i].done, vecs[i].err, vecs[i].code,
                  vecs[i].aref, vecs[i].mode);
      end

      // Async reset out of an error state clears the sticky flags without a clock edge.
      #2;
      sdram_reset = 1'b1;
      #1;
      chk_outs("async_rst_err", 1'b0, 1'b0, 3'd0, 4'd0, 15'h0);

      // Gap boundary: 100 NOPs still legal, the 101st trips the timeout.
      legal_to_pre();
      nops(100);
      chk("gap100_err", 32'(init_err), 32'd0);
      nops(1);
      chk("gap101_err", 32'(init_err), 32'd1);
      chk("gap101_code", 32'(err_code), 32'd2);

      // Reset mid S_AREF, then a complete legal restart.
      legal_to_pre();
      nops(5);
      cyc(P_AREF, 13'h0, 2'd0);
      chk("mid_aref_cnt", 32'(aref_cnt), 32'd1);
      #2;
      sdram_reset = 1'b1;
      #1;
      chk_outs("async_rst_aref", 1'b0, 1'b0, 3'd0, 4'd0, 15'h0);
      legal_to_pre();
      nops(5);
      cyc(P_AREF, 13'h0, 2'd0);
      nops(10);
      cyc(P_AREF, 13'h0, 2'd0);
      nops(10);
      cyc(P_LMR, 13'h033, 2'd0);
      chk_outs("restart", 1'b1, 1'b0, 3'd0, 4'd2, 15'h0033);

      // Extra AREFs saturate at 15; mode word includes the bank bits.
      legal_to_pre();
      for (int k = 0; k < 17; k++) begin
         nops(8);
         cyc(P_AREF, 13'h0, 2'd0);
      end
      chk("aref_sat", 32'(aref_cnt), 32'd15);
      chk("aref_sat_err", 32'(init_err), 32'd0);
      nops(8);
      cyc(P_LMR, 13'h1ABC, 2'b10);
      chk_outs("sat_lmr", 1'b1, 1'b0, 3'd0, 4'd15, 15'h5ABC);

      // AREF, 3 NOP, AREF: a tRFC violation only when spacing checks are built in.
      legal_to_pre();
      nops(5);
      cyc(P_AREF, 13'h0, 2'd0);
      nops(3);
      cyc(P_AREF, 13'h0, 2'd0);
`ifdef SDR_INIT_TIMING_CHECK_EN
      chk_outs("trfc", 1'b0, 1'b1, 3'd5, 4'd1, 15'h0);
`else
      chk_outs("trfc", 1'b0, 1'b0, 3'd0, 4'd2, 15'h0);
      nops(10);
      cyc(P_LMR, 13'h022, 2'd1);
      chk_outs("trfc_lmr", 1'b1, 1'b0, 3'd0, 4'd2, 15'h2022);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
